pmem_line_responder: RTL and testbench

//  Responder end of the line-granular physical-memory handshake (pmem_read/pmem_write/pmem_resp) driven by
//  the L2 cache controller. Models main memory as a line array with programmable fixed latency.

---
 rtl/pmem_line_responder.sv | 125 ++++++++++++
 tb/tb_pmem_line_responder.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/pmem_line_responder.sv
// Line-granular main-memory model answering pmem_read/pmem_write after a fixed LATENCY.
// Optional saturating read/write statistics are built in when PMEM_RESP_STATS_EN is defined.
module pmem_line_responder #(
  parameter int LATENCY     = 10,
  parameter int LINES_LOG2  = 5,
  parameter int OFFSET_BITS = 5
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         pmem_read,
  input  logic         pmem_write,
  input  logic [31:0]  pmem_address,
  input  logic [255:0] pmem_wdata,
  output logic [255:0] pmem_rdata,
  output logic         pmem_resp,
  output logic         proto_err
`ifdef PMEM_RESP_STATS_EN
  ,
  output logic [15:0]  rd_count,
  output logic [15:0]  wr_count
`endif
);

  localparam int LINES = 1 << LINES_LOG2;
  localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  state_t                  r_state;
  logic [CNT_W-1:0]        r_cnt;
  logic                    r_op_wr;
  logic [LINES_LOG2-1:0]   r_idx;
  logic [255:0]            r_wdata;
  logic [255:0]            r_mem [LINES];

  logic                    w_req;
  logic                    w_both;
  logic [LINES_LOG2-1:0]   w_idx_in;
  logic                    w_fire_idle;
  logic                    w_fire_wait;
  logic                    w_fire;
  logic                    w_acc_wr;
  logic [LINES_LOG2-1:0]   w_acc_idx;
  logic [255:0]            w_acc_wdata;
  logic                    w_unused_addr;

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  assign w_req         = pmem_read | pmem_write;
  assign w_both        = pmem_read & pmem_write;
  assign w_idx_in      = pmem_address[OFFSET_BITS +: LINES_LOG2];
  assign w_unused_addr = ^{pmem_address[31:OFFSET_BITS+LINES_LOG2], pmem_address[OFFSET_BITS-1:0]};

  // The access fires on the edge that enters RESP; with LATENCY=1 that is the IDLE edge itself,
  // so the live inputs are used instead of the latched copy.
  assign w_fire_idle = (r_state == S_IDLE) && w_req && (LATENCY == 1);
  assign w_fire_wait = (r_state == S_WAIT) && w_req && (r_cnt == CNT_W'(1));
  assign w_fire      = w_fire_idle | w_fire_wait;
  assign w_acc_wr    = w_fire_idle ? pmem_write : r_op_wr;
  assign w_acc_idx   = w_fire_idle ? w_idx_in   : r_idx;
  assign w_acc_wdata = w_fire_idle ? pmem_wdata : r_wdata;

  // Backing store is deliberately never cleared by reset.
  always_ff @(posedge clk) begin
    if (!rst && w_fire && w_acc_wr) begin
      r_mem[w_acc_idx] <= w_acc_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      pmem_resp  <= 1'b0;
      pmem_rdata <= '0;
      proto_err  <= 1'b0;
`ifdef PMEM_RESP_STATS_EN
      rd_count   <= '0;
      wr_count   <= '0;
`endif
    end else begin
      pmem_resp <= 1'b0;
      if (w_both && (r_state != S_RESP)) begin
        proto_err <= 1'b1;
      end
      case (r_state)
        S_IDLE: begin
          if (w_req) begin
            r_op_wr <= pmem_write;
            r_idx   <= w_idx_in;
            r_wdata <= pmem_wdata;
            r_cnt   <= CNT_W'(LATENCY - 1);
            r_state <= (LATENCY == 1) ? S_RESP : S_WAIT;
          end
        end
        S_WAIT: begin
          if (!w_req) begin
            r_state <= S_IDLE;
          end else if (r_cnt == CNT_W'(1)) begin
            r_state <= S_RESP;
          end else begin
            r_cnt <= r_cnt - CNT_W'(1);
          end
        end
        S_RESP:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
      if (w_fire) begin
        pmem_resp <= 1'b1;
        if (!w_acc_wr) begin
          pmem_rdata <= r_mem[w_acc_idx];
        end
`ifdef PMEM_RESP_STATS_EN
        if (w_acc_wr) begin
          wr_count <= sat_inc(wr_count);
        end else begin
          rd_count <= sat_inc(rd_count);
        end
`endif
      end
    end
  end

endmodule

// File: tb/tb_pmem_line_responder.sv
// Randomized self-checking bench for pmem_line_responder against a line-array reference model.
module tb_pmem_line_responder;
  localparam int L = 10;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         pmem_read = 1'b0;
  logic         pmem_write = 1'b0;
  logic [31:0]  pmem_address = '0;
  logic [255:0] pmem_wdata = '0;
  logic [255:0] pmem_rdata;
  logic         pmem_resp;
  logic         proto_err;
`ifdef PMEM_RESP_STATS_EN
  logic [15:0]  rd_count;
  logic [15:0]  wr_count;
`endif

  int checks = 0;
  int errors = 0;

  logic [255:0] m_mem [32];
  bit           m_val [32];
  logic [255:0] exp_rdata;
  bit           exp_known;

  pmem_line_responder #(.LATENCY(L), .LINES_LOG2(5), .OFFSET_BITS(5)) dut (
    .clk(clk), .rst(rst), .pmem_read(pmem_read), .pmem_write(pmem_write),
    .pmem_address(pmem_address), .pmem_wdata(pmem_wdata), .pmem_rdata(pmem_rdata),
    .pmem_resp(pmem_resp), .proto_err(proto_err)
`ifdef PMEM_RESP_STATS_EN
    , .rd_count(rd_count), .wr_count(wr_count)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  function automatic logic [255:0] rand256();
    logic [255:0] r;
    for (int i = 0; i < 8; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  // Reference model: memory is an array of lines indexed by (address / 32) mod 32.
  function automatic void model_apply(input logic rd, input logic wr, input logic [31:0] addr,
                                      input logic [255:0] wd, input bit aborted);
    int idx;
    if (aborted) return;
    idx = int'((addr / 32) % 32);
    if (wr) begin
      m_mem[idx] = wd;
      m_val[idx] = 1'b1;
    end else if (rd) begin
      exp_known = m_val[idx];
      if (m_val[idx]) exp_rdata = m_mem[idx];
    end
  endfunction

  // Drives one request starting in the current cycle (cycle 0) and observes up to max_cyc cycles.
  task automatic run_txn(input logic rd, input logic wr, input logic [31:0] addr,
                         input logic [255:0] wd, input int drop_at, input int max_cyc,
                         input bit stop_on_resp, output int resp_cyc, output int n_resp,
                         output logic [255:0] rdv);
    resp_cyc = 0;
    n_resp = 0;
    rdv = '0;
    pmem_read = rd;
    pmem_write = wr;
    pmem_address = addr;
    pmem_wdata = wd;
    for (int k = 1; k <= max_cyc; k++) begin
      @(posedge clk); #1;
      if (k == 1) begin
        pmem_address = $urandom;
        pmem_wdata = rand256();
      end
      if (k == drop_at) begin
        pmem_read = 1'b0;
        pmem_write = 1'b0;
      end
      if (pmem_resp) begin
        n_resp++;
        if (resp_cyc == 0) begin
          resp_cyc = k;
          rdv = pmem_rdata;
        end
        pmem_read = 1'b0;
        pmem_write = 1'b0;
        if (stop_on_resp) break;
      end
    end
    if (!stop_on_resp) begin
      pmem_read = 1'b0;
      pmem_write = 1'b0;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    pmem_read = 1'b0;
    pmem_write = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (pmem_resp !== 1'b0) begin errors++; $display("FAIL reset_resp: got %b exp 0", pmem_resp); end
    checks++; if (pmem_rdata !== '0) begin errors++; $display("FAIL reset_rdata: got %h exp 0", pmem_rdata); end
    checks++; if (proto_err !== 1'b0) begin errors++; $display("FAIL reset_proto_err: got %b exp 0", proto_err); end
`ifdef PMEM_RESP_STATS_EN
    checks++; if (rd_count !== 16'd0 || wr_count !== 16'd0) begin
      errors++; $display("FAIL reset_counts: got rd %0d wr %0d exp 0 0", rd_count, wr_count);
    end
`endif
    rst = 1'b0;
    exp_rdata = '0;
    exp_known = 1'b1;
    for (int i = 0; i < 32; i++) m_val[i] = 1'b0;
  endtask

  task automatic test_write_read_alias();
    int rc, nr;
    logic [255:0] rv;
    logic [255:0] w;
    w = {32{8'hA5}};
    run_txn(1'b0, 1'b1, 32'h40, w, 0, L + 3, 1'b0, rc, nr, rv);
    model_apply(1'b0, 1'b1, 32'h40, w, 1'b0);
    checks++; if (rc !== L || nr !== 1) begin errors++; $display("FAIL wr_resp_cycle: got cyc %0d pulses %0d exp cyc %0d pulses 1", rc, nr, L); end
    checks++; if (proto_err !== 1'b0) begin errors++; $display("FAIL wr_proto_err: got %b exp 0", proto_err); end
    run_txn(1'b1, 1'b0, 32'h40, '0, 0, L + 3, 1'b0, rc, nr, rv);
    model_apply(1'b1, 1'b0, 32'h40, '0, 1'b0);
    checks++; if (rc !== L || nr !== 1) begin errors++; $display("FAIL rd_resp_cycle: got cyc %0d pulses %0d exp cyc %0d pulses 1", rc, nr, L); end
    checks++; if (rv !== exp_rdata) begin errors++; $display("FAIL rd_data: got %h exp %h", rv, exp_rdata); end
    run_txn(1'b1, 1'b0, 32'h440, '0, 0, L + 3, 1'b0, rc, nr, rv);
    model_apply(1'b1, 1'b0, 32'h440, '0, 1'b0);
    checks++; if (rv !== exp_rdata || rc !== L) begin errors++; $display("FAIL alias_rd_data: got %h cyc %0d exp %h cyc %0d", rv, rc, exp_rdata, L); end
    checks++; if (pmem_rdata !== exp_rdata) begin errors++; $display("FAIL rdata_hold: got %h exp %h", pmem_rdata, exp_rdata); end
  endtask

  task automatic test_back_to_back();
    int rc, nr;
    logic [255:0] rv;
    logic [255:0] d;
    d = rand256();
    run_txn(1'b0, 1'b1, 32'h80, d, 0, L + 3, 1'b1, rc, nr, rv);
    model_apply(1'b0, 1'b1, 32'h80, d, 1'b0);
    checks++; if (rc !== L) begin errors++; $display("FAIL b2b_wr_cycle: got %0d exp %0d", rc, L); end
    @(posedge clk); #1;
    run_txn(1'b1, 1'b0, 32'h80, '0, 0, L + 2, 1'b0, rc, nr, rv);
    model_apply(1'b1, 1'b0, 32'h80, '0, 1'b0);
    checks++; if (rc !== L || nr !== 1) begin errors++; $display("FAIL b2b_rd_cycle: got cyc %0d pulses %0d exp cyc %0d pulses 1", rc, nr, L); end
    checks++; if (rv !== exp_rdata) begin errors++; $display("FAIL b2b_rd_data: got %h exp %h", rv, exp_rdata); end
  endtask

  task automatic test_abort();
    int rc, nr;
    logic [255:0] rv;
    run_txn(1'b1, 1'b0, 32'h100, '0, 4, 20, 1'b0, rc, nr, rv);
    checks++; if (nr !== 0) begin errors++; $display("FAIL abort_resp: got %0d pulses exp 0", nr); end
    checks++; if (pmem_rdata !== exp_rdata) begin errors++; $display("FAIL abort_rdata: got %h exp %h", pmem_rdata, exp_rdata); end
  endtask

  task automatic test_reset_mid();
    int rc, nr, seen;
    logic [255:0] rv;
    logic [255:0] pre;
    pre = rand256();
    run_txn(1'b0, 1'b1, 32'h60, pre, 0, L + 2, 1'b0, rc, nr, rv);
    model_apply(1'b0, 1'b1, 32'h60, pre, 1'b0);
    seen = 0;
    pmem_write = 1'b1;
    pmem_address = 32'h60;
    pmem_wdata = ~pre;
    for (int k = 1; k <= 5; k++) begin
      @(posedge clk); #1;
      if (pmem_resp) seen++;
    end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    pmem_write = 1'b0;
    for (int k = 0; k < 15; k++) begin
      @(posedge clk); #1;
      if (pmem_resp) seen++;
    end
    exp_rdata = '0;
    exp_known = 1'b1;
    checks++; if (seen !== 0) begin errors++; $display("FAIL rstmid_resp: got %0d pulses exp 0", seen); end
    checks++; if (pmem_rdata !== '0) begin errors++; $display("FAIL rstmid_rdata: got %h exp 0", pmem_rdata); end
    run_txn(1'b1, 1'b0, 32'h60, '0, 0, L + 2, 1'b0, rc, nr, rv);
    model_apply(1'b1, 1'b0, 32'h60, '0, 1'b0);
    checks++; if (rv !== exp_rdata || rc !== L) begin errors++; $display("FAIL rstmid_retained: got %h cyc %0d exp %h cyc %0d", rv, rc, exp_rdata, L); end
  endtask

  task automatic test_proto_err();
    int rc, nr;
    logic [255:0] rv;
    logic [255:0] wd;
    wd = rand256();
    run_txn(1'b1, 1'b1, 32'h20, wd, 0, L + 2, 1'b0, rc, nr, rv);
    model_apply(1'b1, 1'b1, 32'h20, wd, 1'b0);
    checks++; if (proto_err !== 1'b1) begin errors++; $display("FAIL proto_set: got %b exp 1", proto_err); end
    checks++; if (rc !== L || pmem_rdata !== exp_rdata) begin errors++; $display("FAIL proto_wr_prio: got cyc %0d rdata %h exp cyc %0d rdata %h", rc, pmem_rdata, L, exp_rdata); end
    run_txn(1'b1, 1'b0, 32'h20, '0, 0, L + 2, 1'b0, rc, nr, rv);
    model_apply(1'b1, 1'b0, 32'h20, '0, 1'b0);
    checks++; if (rv !== exp_rdata) begin errors++; $display("FAIL proto_line: got %h exp %h", rv, exp_rdata); end
    checks++; if (proto_err !== 1'b1) begin errors++; $display("FAIL proto_sticky: got %b exp 1", proto_err); end
  endtask

  task automatic test_random();
    int rc, nr, drop;
    bit is_rd, aborted;
    logic [31:0] addr;
    logic [255:0] rv, wd;
    for (int i = 0; i < 32; i++) begin
      wd = rand256();
      addr = 32'(i * 32) | ($urandom & 32'hFFFF_FC1F);
      run_txn(1'b0, 1'b1, addr, wd, 0, L + 2, 1'b0, rc, nr, rv);
      model_apply(1'b0, 1'b1, addr, wd, 1'b0);
      checks++; if (rc !== L || nr !== 1) begin errors++; $display("FAIL fill_resp[%0d]: got cyc %0d pulses %0d exp cyc %0d", i, rc, nr, L); end
    end
    for (int t = 0; t < 40; t++) begin
      is_rd = $urandom_range(0, 1) == 1;
      addr = $urandom;
      wd = rand256();
      drop = ($urandom_range(0, 3) == 0) ? $urandom_range(1, L - 1) : 0;
      aborted = drop != 0;
      run_txn(is_rd, !is_rd, addr, wd, drop, aborted ? 20 : L + 2, 1'b0, rc, nr, rv);
      model_apply(is_rd, !is_rd, addr, wd, aborted);
      checks++;
      if (aborted) begin
        if (nr !== 0) begin errors++; $display("FAIL rand_abort[%0d]: got %0d pulses exp 0", t, nr); end
      end else if (rc !== L || nr !== 1) begin
        errors++; $display("FAIL rand_resp[%0d]: got cyc %0d pulses %0d exp cyc %0d pulses 1", t, rc, nr, L);
      end
      if (exp_known) begin
        checks++; if (pmem_rdata !== exp_rdata) begin errors++; $display("FAIL rand_rdata[%0d]: got %h exp %h", t, pmem_rdata, exp_rdata); end
      end
    end
    checks++; if (proto_err !== 1'b1) begin errors++; $display("FAIL rand_proto_sticky: got %b exp 1", proto_err); end
  endtask

`ifdef PMEM_RESP_STATS_EN
  task automatic test_stats();
    int rc, nr;
    logic [255:0] rv;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    for (int i = 0; i < 3; i++) run_txn(1'b0, 1'b1, $urandom, rand256(), 0, L + 2, 1'b0, rc, nr, rv);
    for (int i = 0; i < 2; i++) run_txn(1'b1, 1'b0, $urandom, '0, 0, L + 2, 1'b0, rc, nr, rv);
    run_txn(1'b1, 1'b0, $urandom, '0, 3, 20, 1'b0, rc, nr, rv);
    run_txn(1'b0, 1'b1, $urandom, rand256(), 6, 20, 1'b0, rc, nr, rv);
    checks++; if (wr_count !== 16'd3) begin errors++; $display("FAIL stats_wr: got %0d exp 3", wr_count); end
    checks++; if (rd_count !== 16'd2) begin errors++; $display("FAIL stats_rd: got %0d exp 2", rd_count); end
  endtask
`endif

  initial begin
    test_reset();
    test_write_read_alias();
    test_back_to_back();
    test_abort();
    test_reset_mid();
    test_proto_err();
    test_random();
`ifdef PMEM_RESP_STATS_EN
    test_stats();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
